// File: rtl/serial_addition_module_8bit.sv
// Bit-serial adder: one sum bit per clock, LSB first, single carry register.
// Signed overflow forces the reported sum to zero; Cout is always reported.
module serial_addition_module_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             co;
    logic [WIDTH-1:0] sum_next;
    logic             last;

    // Full adder on the current operand LSBs and the running carry
    always_comb begin
        s        = a_sr[0] ^ b_sr[0] ^ carry;
        co       = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        sum_next = {s, sum_sr[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, operand/sum shifting and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Out      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        sum_sr <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= co;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // carry holds the carry into the MSB here
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        Cout     <= co;
                        Overflow <= carry ^ co;
                        Out      <= (carry ^ co) ? '0 : sum_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
